// File: rtl/bus_track_if.sv
// CPU-side bus bundle for bus_track: strobes, upper address bits, and the
// tracker/decoder results fed to the DRAM/ROM controller.
interface bus_track_if;
    logic [23:20] A;
    logic         nAS;
    logic         nDTACK;
    logic         BACT;
    logic [3:1]   BACTr;
    logic         RAMCS;
    logic         RAMCS0X;
    logic         ROMCS;
    logic         RefClk;
    logic         nBERR;

    // The CPU/bench drives strobes and address and observes the results.
    modport master (
        output A, nAS, nDTACK,
        input  BACT, BACTr, RAMCS, RAMCS0X, ROMCS, RefClk, nBERR
    );

    modport slave (
        input  A, nAS, nDTACK,
        output BACT, BACTr, RAMCS, RAMCS0X, ROMCS, RefClk, nBERR
    );
endinterface

// File: rtl/bus_track.sv
// Bus-cycle tracker, boot-overlay address decoder, refresh timebase and
// bus-error timeout sitting upstream of the DRAM/ROM controller.
module bus_track #(
    parameter int REF_HALF = 195,
    parameter int BERR_CYC = 4095
) (
    input  logic        CLK,
    input  logic        nRESET,
    bus_track_if.slave  bus
);
    localparam logic [9:0]  REF_LAST = 10'(REF_HALF - 1);
    localparam logic [11:0] BERR_MAX = 12'(BERR_CYC);

    logic        bact;
    logic [3:1]  bactR;
    logic        overlay;
    logic        firstClk;
    logic        romRegion;
    logic        ramRegion;
    logic [9:0]  refCnt;
    logic        refClk;
    logic [11:0] berrCnt;
    logic        nBerr;

    // Access tracking: BACT mirrors the strobe one edge late, BACTr delays it further.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            bact  <= 1'b0;
            bactR <= 3'b000;
        end else begin
            bact  <= !bus.nAS;
            bactR <= {bactR[2:1], bact};
        end
    end

    assign firstClk = bact && !bactR[1];

    // Boot overlay: ROM mirrors low memory until the first ROM-region access.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            overlay <= 1'b1;
        end else if (firstClk && romRegion) begin
            overlay <= 1'b0;
        end
    end

    always_comb begin
        ramRegion = (bus.A[23:22] == 2'b00);
        romRegion = (bus.A == 4'h4);
    end

    // Free-running refresh square wave, independent of bus traffic.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            refCnt <= 10'd0;
            refClk <= 1'b0;
        end else if (refCnt == REF_LAST) begin
            refCnt <= 10'd0;
            refClk <= !refClk;
        end else begin
            refCnt <= refCnt + 10'd1;
        end
    end

    // Timeout counter saturates so nBERR stays asserted until the cycle ends.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            berrCnt <= 12'd0;
        end else if (!bact) begin
            berrCnt <= 12'd0;
        end else if (bus.nDTACK && (berrCnt != BERR_MAX)) begin
            berrCnt <= berrCnt + 12'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            nBerr <= 1'b1;
        end else begin
            nBerr <= !(bact && (berrCnt == BERR_MAX));
        end
    end

    assign bus.BACT    = bact;
    assign bus.BACTr   = bactR;
    assign bus.RAMCS0X = ramRegion;
    assign bus.RAMCS   = ramRegion && !overlay;
    assign bus.ROMCS   = romRegion || (overlay && ramRegion);
    assign bus.RefClk  = refClk;
    assign bus.nBERR   = nBerr;

    // ROM region is outside A[23:22]==0, so the two selects cannot overlap.
    a_cs_exclusive: assert property (@(posedge CLK) disable iff (!nRESET)
        !(bus.RAMCS && bus.ROMCS));
endmodule

// File: tb/tb_bus_track.sv
// Directed bench for bus_track with REF_HALF = 5 and BERR_CYC = 8.
module tb_bus_track;
  logic CLK;
  logic nRESET;
  int tests_run;
  int tests_failed;

  bus_track_if bus();

  bus_track #(.REF_HALF(5), .BERR_CYC(8)) dut (
    .CLK   (CLK),
    .nRESET(nRESET),
    .bus   (bus)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    nRESET = 1'b0;
    bus.A = 4'h0;
    bus.nAS = 1'b1;
    bus.nDTACK = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    nRESET = 1'b1;
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    bus.A = 4'h0;
    bus.nAS = 1'b0;
    bus.nDTACK = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    if (bus.BACT !== 1'b0) begin $display("FAIL reset_bact: got %b expected 0", bus.BACT); tests_failed++; end
    tests_run++;
    if (bus.BACTr !== 3'b000) begin $display("FAIL reset_bactr: got %b expected 000", bus.BACTr); tests_failed++; end
    tests_run++;
    if (bus.RefClk !== 1'b0) begin $display("FAIL reset_refclk: got %b expected 0", bus.RefClk); tests_failed++; end
    tests_run++;
    if (bus.nBERR !== 1'b1) begin $display("FAIL reset_nberr: got %b expected 1", bus.nBERR); tests_failed++; end
    tests_run++;
    if (bus.RAMCS !== 1'b0) begin $display("FAIL reset_ramcs: got %b expected 0", bus.RAMCS); tests_failed++; end
    tests_run++;
    if (bus.ROMCS !== 1'b1) begin $display("FAIL reset_romcs: got %b expected 1", bus.ROMCS); tests_failed++; end
    tests_run++;
    if (bus.RAMCS0X !== 1'b1) begin $display("FAIL reset_ramcs0x: got %b expected 1", bus.RAMCS0X); tests_failed++; end
    tests_run++;
    bus.nAS = 1'b1;
  endtask

  task automatic test_refresh();
    logic exp_clk;
    apply_reset();
    for (int k = 1; k <= 200; k++) begin
      // Second half toggles the strobe to show the timebase ignores bus traffic.
      if (k > 100) bus.nAS = 1'($urandom_range(0, 1));
      tick();
      exp_clk = 1'(((k / 5) % 2));
      if (bus.RefClk !== exp_clk) begin
        $display("FAIL refclk_edge%0d: got %b expected %b", k, bus.RefClk, exp_clk);
        tests_failed++;
      end
      tests_run++;
    end
    bus.nAS = 1'b1;
    tick();
  endtask

  task automatic test_overlay();
    apply_reset();
    bus.A = 4'h4;
    bus.nAS = 1'b0;
    tick();
    bus.A = 4'h0;
    #1;
    if (bus.ROMCS !== 1'b1 || bus.RAMCS !== 1'b0) begin
      $display("FAIL overlay_before_first_clk: got rom=%b ram=%b expected rom=1 ram=0", bus.ROMCS, bus.RAMCS);
      tests_failed++;
    end
    tests_run++;
    bus.A = 4'h4;
    tick();
    if (bus.BACTr !== 3'b001) begin $display("FAIL overlay_bactr1: got %b expected 001", bus.BACTr); tests_failed++; end
    tests_run++;
    bus.A = 4'h0;
    #1;
    if (bus.RAMCS !== 1'b1 || bus.ROMCS !== 1'b0) begin
      $display("FAIL overlay_cleared: got ram=%b rom=%b expected ram=1 rom=0", bus.RAMCS, bus.ROMCS);
      tests_failed++;
    end
    tests_run++;
    bus.A = 4'h4;
    tick();
    tick();
    bus.nAS = 1'b1;
    bus.A = 4'h0;
    tick();
    if (bus.RAMCS !== 1'b1 || bus.ROMCS !== 1'b0 || bus.RAMCS0X !== 1'b1) begin
      $display("FAIL overlay_ram_a0: got ram=%b rom=%b raw=%b expected ram=1 rom=0 raw=1", bus.RAMCS, bus.ROMCS, bus.RAMCS0X);
      tests_failed++;
    end
    tests_run++;
    bus.A = 4'h4;
    bus.nAS = 1'b0;
    tick();
    if (bus.ROMCS !== 1'b1 || bus.RAMCS !== 1'b0) begin
      $display("FAIL overlay_rom_a4: got rom=%b ram=%b expected rom=1 ram=0", bus.ROMCS, bus.RAMCS);
      tests_failed++;
    end
    tests_run++;
    tick();
    bus.nAS = 1'b1;
    tick();
    tick();
    bus.A = 4'h3;
    #1;
    if (bus.RAMCS !== 1'b1 || bus.ROMCS !== 1'b0) begin
      $display("FAIL overlay_stays_clear: got ram=%b rom=%b expected ram=1 rom=0", bus.RAMCS, bus.ROMCS);
      tests_failed++;
    end
    tests_run++;
    bus.A = 4'h8;
    #1;
    if ({bus.RAMCS0X, bus.RAMCS, bus.ROMCS} !== 3'b000) begin
      $display("FAIL decode_a8: got raw/ram/rom=%b expected 000", {bus.RAMCS0X, bus.RAMCS, bus.ROMCS});
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_overlay_sticky();
    apply_reset();
    bus.A = 4'h0;
    bus.nAS = 1'b0;
    tick();
    tick();
    bus.A = 4'h4;
    tick();
    tick();
    bus.nAS = 1'b1;
    tick();
    bus.A = 4'h0;
    #1;
    if (bus.ROMCS !== 1'b1 || bus.RAMCS !== 1'b0) begin
      $display("FAIL overlay_sticky: got rom=%b ram=%b expected rom=1 ram=0", bus.ROMCS, bus.RAMCS);
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_bact_pipeline();
    logic [3:0] exp_q[$];
    logic [3:0] exp_v;
    logic [3:0] got;
    apply_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    bus.nAS = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.nAS = 1'b1;
      exp_v = exp_q.pop_front();
      got = {bus.BACTr, bus.BACT};
      if (got !== exp_v) begin
        $display("FAIL pipeline_cycle%0d: got bactr,bact=%b expected %b", i, got, exp_v);
        tests_failed++;
      end
      tests_run++;
    end
  endtask

  task automatic test_timeout();
    logic exp_n;
    apply_reset();
    bus.nAS = 1'b0;
    tick();
    for (int j = 1; j <= 12; j++) begin
      tick();
      exp_n = (j >= 9) ? 1'b0 : 1'b1;
      if (bus.nBERR !== exp_n) begin
        $display("FAIL berr_edge%0d: got %b expected %b", j, bus.nBERR, exp_n);
        tests_failed++;
      end
      tests_run++;
    end
    bus.nAS = 1'b1;
    tick();
    if (bus.BACT !== 1'b0 || bus.nBERR !== 1'b0) begin
      $display("FAIL berr_bact_fall: got bact=%b nberr=%b expected bact=0 nberr=0", bus.BACT, bus.nBERR);
      tests_failed++;
    end
    tests_run++;
    tick();
    if (bus.nBERR !== 1'b1) begin $display("FAIL berr_release: got %b expected 1", bus.nBERR); tests_failed++; end
    tests_run++;
    tick();
    // Acknowledge arrives on the edge that would have saturated the counter.
    bus.nAS = 1'b0;
    tick();
    for (int j = 1; j <= 12; j++) begin
      if (j >= 8) bus.nDTACK = 1'b0;
      tick();
      if (bus.nBERR !== 1'b1) begin
        $display("FAIL late_dtack_edge%0d: got %b expected 1", j, bus.nBERR);
        tests_failed++;
      end
      tests_run++;
    end
    bus.nAS = 1'b1;
    bus.nDTACK = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_n;
    apply_reset();
    bus.nAS = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    if (bus.BACT !== 1'b1) begin $display("FAIL b2b_first_active: got %b expected 1", bus.BACT); tests_failed++; end
    tests_run++;
    bus.nAS = 1'b1;
    tick();
    if (bus.BACT !== 1'b0 || bus.nBERR !== 1'b1) begin
      $display("FAIL b2b_gap: got bact=%b nberr=%b expected bact=0 nberr=1", bus.BACT, bus.nBERR);
      tests_failed++;
    end
    tests_run++;
    bus.nAS = 1'b0;
    tick();
    if ({bus.BACT, bus.BACTr[1]} !== 2'b10) begin
      $display("FAIL b2b_fresh_first_clk: got bact,bactr1=%b expected 10", {bus.BACT, bus.BACTr[1]});
      tests_failed++;
    end
    tests_run++;
    for (int j = 1; j <= 10; j++) begin
      tick();
      exp_n = (j >= 9) ? 1'b0 : 1'b1;
      if (bus.nBERR !== exp_n) begin
        $display("FAIL b2b_berr_edge%0d: got %b expected %b", j, bus.nBERR, exp_n);
        tests_failed++;
      end
      tests_run++;
    end
    bus.nAS = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.A = 4'h4;
    bus.nAS = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.A = 4'h0;
    for (int i = 0; i < 10; i++) tick();
    if (bus.nBERR !== 1'b0 || bus.BACT !== 1'b1 || bus.ROMCS !== 1'b0) begin
      $display("FAIL async_pre: got nberr=%b bact=%b rom=%b expected nberr=0 bact=1 rom=0", bus.nBERR, bus.BACT, bus.ROMCS);
      tests_failed++;
    end
    tests_run++;
    @(negedge CLK);
    #1;
    nRESET = 1'b0;
    #1;
    if (bus.nBERR !== 1'b1) begin $display("FAIL async_nberr: got %b expected 1", bus.nBERR); tests_failed++; end
    tests_run++;
    if (bus.BACT !== 1'b0 || bus.BACTr !== 3'b000) begin
      $display("FAIL async_bact: got bact=%b bactr=%b expected bact=0 bactr=000", bus.BACT, bus.BACTr);
      tests_failed++;
    end
    tests_run++;
    if (bus.ROMCS !== 1'b1 || bus.RAMCS !== 1'b0) begin
      $display("FAIL async_overlay: got rom=%b ram=%b expected rom=1 ram=0", bus.ROMCS, bus.RAMCS);
      tests_failed++;
    end
    tests_run++;
    #1;
    nRESET = 1'b1;
    tick();
    if (bus.BACT !== 1'b1) begin $display("FAIL async_restart: got %b expected 1", bus.BACT); tests_failed++; end
    tests_run++;
    bus.nAS = 1'b1;
    tick();
  endtask

  // Sequence and report
  initial begin
    tests_run = 0;
    tests_failed = 0;
    nRESET = 1'b0;
    bus.A = 4'h0;
    bus.nAS = 1'b1;
    bus.nDTACK = 1'b1;
    test_reset();
    test_refresh();
    test_overlay();
    test_overlay_sticky();
    test_bact_pipeline();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/bus_track.md
# bus_track

Bus-cycle tracker, address decoder and refresh timebase that sits directly upstream of the DRAM/ROM controller. From the 68HC000 strobes and the upper address bits it produces the registered access-active flag and its delayed copies, the RAM and ROM chip selects (including the boot-time ROM overlay), and the slow square-wave refresh clock. It also enforces a bus-error timeout on cycles that are never acknowledged.

## Interface
Parameters:
- REF_HALF, 195: CLK cycles per half period of RefClk. Full refresh period is 2*REF_HALF cycles. Legal range is 2..1023.
- BERR_CYC, 4095: CLK cycles of unacknowledged BACT before nBERR asserts. Legal range is 2..4095.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRESET  in  1  reset; asynchronous, active-low.
- A  in  4  CPU address bits [23:20].
- nAS  in  1  CPU address strobe, active-low.
- nDTACK  in  1  data acknowledge seen on the bus, active-low.
- BACT  out  1  registered bus-cycle-active flag.
- BACTr  out  3  delayed copies of BACT, indexed [3:1].
- RAMCS  out  1  RAM select, gated by the overlay flag.
- RAMCS0X  out  1  raw RAM-region decode, overlay ignored.
- ROMCS  out  1  ROM select.
- RefClk  out  1  refresh square wave.
- nBERR  out  1  bus error, active-low, registered.

## Operation
- **BACT.** BACT <= !nAS on each CLK edge.
- **BACTr.** BACTr[1] <= BACT; BACTr[2] <= BACTr[1]; BACTr[3] <= BACTr[2]. This is a plain shift register with no gating.
- **First clock of an access.** Defined as BACT && !BACTr[1].
- **Overlay register.**
  - Set to 1 by reset.
  - Cleared on the edge where the first-clock condition holds and A == 4'h4 (ROM region).
  - Once cleared, it stays 0 until the next reset.
- **Decode (combinational from A and the overlay register).**
  - RAMCS0X = (A[23:22] == 0).
  - RAMCS = RAMCS0X && !Overlay.
  - ROMCS = (A == 4'h4) || (Overlay && RAMCS0X).
  - RAMCS and ROMCS are never both 1.
- **Refresh timebase.**
  - RefCnt counts 0..REF_HALF-1 and wraps to 0.
  - RefClk toggles on the edge where RefCnt == REF_HALF-1.
  - The timebase free-runs and is independent of bus activity.
- **Timeout counter.**
  - BerrCnt (12 bits) is cleared whenever BACT == 0.
  - It increments while BACT && nDTACK && BerrCnt != BERR_CYC.
  - It holds while nDTACK is low.
  - It saturates at BERR_CYC.
- **nBERR.**
  - nBERR <= !(BACT && BerrCnt == BERR_CYC).
  - It releases on the edge after BACT falls.
- **Reset values.** BACT = 0, BACTr = 3'b000, Overlay = 1, RefCnt = 0, RefClk = 0, BerrCnt = 0, nBERR = 1.
- **Decode outputs during reset.** They follow A with Overlay = 1: A = 0 gives RAMCS = 0, RAMCS0X = 1, ROMCS = 1.

## Timing
- **BACT latency.** BACT rises 1 CLK edge after nAS is sampled low and falls 1 edge after nAS is sampled high.
- **BACTr latency.** BACTr[k] lags BACT by exactly k edges.
- **Short access.** A one-cycle nAS low gives a single-cycle BACT pulse. BACTr[1..3] then pulse in successive cycles.
- **Overlay clear.** The clear takes effect on the same edge on which BACTr[1] becomes 1. RAMCS for A = 0 is valid from the next cycle.
- **Overlay stickiness.** A ROM-region access that is not on a first clock (BACTr[1] already 1) does not clear the overlay.
- **RefClk first edge.** The first rising edge of RefClk occurs at edge REF_HALF after reset deassertion. The output is high for REF_HALF cycles and low for REF_HALF cycles, exact with no drift.
- **Reset mid-cycle.** Asynchronous reset clears all registers immediately, including during an active access or an asserted nBERR. After release, an nAS held low causes BACT to rise on the first edge.
- **nBERR assertion.** nBERR asserts at edge BERR_CYC+1 after BACT rises, provided nDTACK stays high.
- **Late DTACK.** If nDTACK goes low on the same edge that saturation would be reached, the counter holds and nBERR does not assert.
- **Back-to-back cycles.** If nAS rises for one cycle between two accesses, BACT drops for one cycle. BerrCnt clears, and the second access starts a fresh first clock.

## Test plan
- **Reset and boot overlay.** Hold nRESET = 0 with A = 0 -> BACT = 0, BACTr = 0, RefClk = 0, nBERR = 1, RAMCS = 0, ROMCS = 1, RAMCS0X = 1.
- **Overlay clear and stickiness.**
  - Release reset, drive A = 4'h4 and nAS low for 4 cycles -> Overlay clears on the cycle BACTr[1] rises.
  - Then drive A = 0 -> RAMCS = 1, ROMCS = 0.
  - A later A = 4'h4 access gives ROMCS = 1 with RAMCS = 0.
  - Overlay never returns to 1 without a reset.
- **BACT pipeline.** nAS low for exactly 1 cycle -> BACT high for 1 cycle, then BACTr[1], BACTr[2] and BACTr[3] each high for 1 cycle in successive cycles.
- **Refresh timebase.** Use REF_HALF = 5 with no bus activity -> RefClk rises at edge 5 after reset and falls at edge 10; the period is 10 cycles across 100 cycles with no drift. Repeat while toggling nAS to confirm bus activity has no effect.
- **Bus timeout.** Use BERR_CYC = 8, hold nAS low with nDTACK high -> nBERR = 0 at edge 9 after BACT rises; nBERR returns to 1 one edge after BACT falls. Repeat with nDTACK low at cycle 7 -> nBERR stays 1.
- **Asynchronous reset mid-error.** With nBERR = 0 and BACT = 1, pulse nRESET low between clock edges -> nBERR = 1, BACT = 0 and Overlay = 1 immediately, without waiting for a clock edge.
